// File: rtl/vec_stream_loader.sv
// vec_stream_loader: framed byte-stream loader for the dot-product vector store.
// Frame = sync byte, 4 A elements, 4 B elements, 8-bit wrapping checksum.
// The payload is buffered and written out only after the checksum matches.
// Stream handshake: a byte moves on a clock edge exactly when s_valid & s_ready
// are both high. s_ready depends only on the current state, never on s_valid.
module vec_stream_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       wr_a,
   output logic       wr_b,
   output logic [1:0] wr_index,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       load_done,
   output logic       load_err
);

   localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECV   = 2'd1,
      S_CSUM   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [7:0]    data_buf [8];
   // RECV: next buffer slot. COMMIT: next element to present (0 = all presented).
   logic [2:0]    cnt;
   logic [7:0]    sum;
   logic [TW-1:0] idle_cnt;

   logic          xfer;
   logic          is_sync;
   logic          in_frame;
   logic          timeout_hit;
   logic          csum_ok;

   logic          wr_a_d;
   logic          wr_b_d;
   logic [1:0]    wr_index_d;
   logic [7:0]    wr_data_d;
   logic          load_done_d;
   logic          load_err_d;

   assign s_ready     = (state != S_COMMIT);
   assign xfer        = s_valid & s_ready;
   assign is_sync     = (s_data == SYNC_BYTE);
   assign in_frame    = (state == S_RECV) || (state == S_CSUM);
   assign timeout_hit = in_frame && !xfer && (idle_cnt == T_LAST);
   assign csum_ok     = (s_data == sum);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state decode and next values of the registered outputs.
   always_comb begin
      state_next  = state;
      wr_a_d      = 1'b0;
      wr_b_d      = 1'b0;
      wr_index_d  = wr_index;
      wr_data_d   = wr_data;
      load_done_d = 1'b0;
      load_err_d  = load_err;
      case (state)
         S_IDLE: begin
            if (xfer && is_sync) begin
               state_next = S_RECV;
               load_err_d = 1'b0;
            end
         end
         S_RECV: begin
            if (xfer) begin
               if (cnt == 3'd7) state_next = S_CSUM;
            end else if (timeout_hit) begin
               state_next = S_IDLE;
               load_err_d = 1'b1;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               if (csum_ok) begin
                  // First write (A[0]) goes out on the same edge that accepts the checksum.
                  state_next = S_COMMIT;
                  wr_a_d     = 1'b1;
                  wr_index_d = 2'd0;
                  wr_data_d  = data_buf[0];
               end else begin
                  state_next = S_IDLE;
                  load_err_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_next = S_IDLE;
               load_err_d = 1'b1;
            end
         end
         S_COMMIT: begin
            if (cnt == 3'd0) begin
               state_next  = S_IDLE;
               load_done_d = 1'b1;
            end else begin
               wr_a_d     = ~cnt[2];
               wr_b_d     = cnt[2];
               wr_index_d = cnt[1:0];
               wr_data_d  = data_buf[cnt];
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_a      <= 1'b0;
         wr_b      <= 1'b0;
         wr_index  <= 2'd0;
         wr_data   <= 8'd0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         wr_a      <= wr_a_d;
         wr_b      <= wr_b_d;
         wr_index  <= wr_index_d;
         wr_data   <= wr_data_d;
         load_done <= load_done_d;
         load_err  <= load_err_d;
         busy      <= (state_next != S_IDLE);
      end
   end

   // Payload buffer, running checksum, element counter and inter-byte idle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 3'd0;
         sum      <= 8'd0;
         idle_cnt <= '0;
         for (int i = 0; i < 8; i++) data_buf[i] <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer && is_sync) begin
                  cnt      <= 3'd0;
                  sum      <= 8'd0;
                  idle_cnt <= '0;
               end
            end
            S_RECV: begin
               if (xfer) begin
                  data_buf[cnt] <= s_data;
                  sum           <= sum + s_data;
                  cnt           <= cnt + 3'd1;
                  idle_cnt      <= '0;
               end else if (timeout_hit) begin
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  cnt      <= 3'd1;
                  idle_cnt <= '0;
               end else if (timeout_hit) begin
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_COMMIT: begin
               if (cnt != 3'd0) cnt <= cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_stream_loader.sv
// Testbench for vec_stream_loader: directed frames plus a randomized byte stream,
// checked against a byte-level frame parser model kept in the bench.
module tb_vec_stream_loader;

   localparam int T = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       wr_a;
   logic       wr_b;
   logic [1:0] wr_index;
   logic [7:0] wr_data;
   logic       busy;
   logic       load_done;
   logic       load_err;

   vec_stream_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .wr_a(wr_a), .wr_b(wr_b), .wr_index(wr_index), .wr_data(wr_data),
      .busy(busy), .load_done(load_done), .load_err(load_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [11:0] exp_q[$];
   int          done_seen = 0;
   int          done_exp  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Frame parser over accepted bytes: 0 = hunting sync, 1 = payload, 2 = checksum.
   int         m_state  = 0;
   logic [7:0] m_pl[8];
   int         m_n      = 0;
   logic [7:0] m_sum    = 8'd0;
   logic       m_err    = 1'b0;
   int         idle_run = 0;

   function automatic void model_flush();
      if (m_state != 0 && idle_run >= T) begin
         m_state = 0;
         m_err   = 1'b1;
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [11:0] e;
      model_flush();
      case (m_state)
         0: if (b == 8'hA5) begin
               m_state = 1; m_err = 1'b0; m_n = 0; m_sum = 8'd0;
            end
         1: begin
               m_pl[m_n] = b;
               m_sum     = m_sum + b;
               m_n++;
               if (m_n == 8) m_state = 2;
            end
         default: begin
               if (b == m_sum) begin
                  for (int k = 0; k < 8; k++) begin
                     e[11]  = (k < 4);
                     e[10]  = (k >= 4);
                     e[9:8] = k[1:0];
                     e[7:0] = m_pl[k];
                     exp_q.push_back(e);
                  end
                  done_exp++;
               end else begin
                  m_err = 1'b1;
               end
               m_state = 0;
            end
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check_eq("strobe_excl", {31'd0, wr_a & wr_b}, 32'd0);
         if (wr_a || wr_b) begin
            if (exp_q.size() == 0) check_eq("wr_unexp", {20'd0, wr_a, wr_b, wr_index, wr_data}, 32'd0);
            else check_eq("wr", {20'd0, wr_a, wr_b, wr_index, wr_data}, {20'd0, exp_q.pop_front()});
         end
         if (load_done) done_seen++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         idle_run++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
      idle(gap);
      s_valid = 1'b1;
      s_data  = b;
      waited  = 0;
      while (!s_ready && waited < 40) begin
         @(negedge clk);
         waited++;
         idle_run++;
      end
      if (!s_ready) begin
         check_eq("ready_wait", {31'd0, s_ready}, 32'd1);
      end else begin
         model_byte(b);
         idle_run = 0;
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] p[8], input logic [7:0] cs, input int maxgap);
      int w;
      send_byte(8'hA5, $urandom_range(0, maxgap), w);
      for (int k = 0; k < 8; k++) send_byte(p[k], $urandom_range(0, maxgap), w);
      send_byte(cs, $urandom_range(0, maxgap), w);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [7:0]  p[8];
   logic [7:0]  cs;
   logic [11:0] e;
   int          w;
   int          gap;

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = 8'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", {31'd0, s_ready}, 32'd1);
      check_eq("rst_busy",  {31'd0, busy}, 32'd0);
      check_eq("rst_err",   {31'd0, load_err}, 32'd0);
      check_eq("rst_done",  {31'd0, load_done}, 32'd0);
      check_eq("rst_wr",    {20'd0, wr_a, wr_b, wr_index, wr_data}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Case 1: nominal frame, exact commit timing.
      p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_pkt(p, 8'h24, 0);
      for (int k = 0; k < 8; k++) begin
         e[11] = (k < 4); e[10] = (k >= 4); e[9:8] = k[1:0]; e[7:0] = p[k];
         check_eq("t1_wr", {20'd0, wr_a, wr_b, wr_index, wr_data}, {20'd0, e});
         check_eq("t1_ready_low", {31'd0, s_ready}, 32'd0);
         check_eq("t1_busy", {31'd0, busy}, 32'd1);
         idle(1);
      end
      check_eq("t1_done", {31'd0, load_done}, 32'd1);
      check_eq("t1_strobes_low", {30'd0, wr_a, wr_b}, 32'd0);
      check_eq("t1_ready_back", {31'd0, s_ready}, 32'd1);
      check_eq("t1_err", {31'd0, load_err}, {31'd0, m_err});
      idle(1);
      check_eq("t1_done_pulse", {31'd0, load_done}, 32'd0);
      check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);

      // Case 2: bad checksum, then a good frame clears the error at its sync.
      send_pkt(p, 8'h25, 1);
      idle(12);
      check_eq("t2_err", {31'd0, load_err}, {31'd0, m_err});
      send_byte(8'hA5, 0, w);
      check_eq("t2_err_clr", {31'd0, load_err}, {31'd0, m_err});
      for (int k = 0; k < 8; k++) send_byte(p[k], 0, w);
      send_byte(8'h24, 0, w);
      idle(12);
      check_eq("t2_err_after", {31'd0, load_err}, {31'd0, m_err});

      // Case 3: junk before the frame.
      send_byte(8'h00, 0, w);
      send_byte(8'hFF, 1, w);
      send_byte(8'h5A, 0, w);
      send_pkt(p, 8'h24, 0);
      idle(12);
      check_eq("t3_busy", {31'd0, busy}, 32'd0);

      // Case 4: timeout mid-payload, then a frame whose payload is all sync bytes.
      send_byte(8'hA5, 0, w);
      send_byte(8'h11, 0, w);
      send_byte(8'h22, 0, w);
      send_byte(8'h33, 0, w);
      idle(T + 2);
      model_flush();
      check_eq("t4_err", {31'd0, load_err}, {31'd0, m_err});
      check_eq("t4_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 8; k++) p[k] = 8'hA5;
      send_pkt(p, 8'h28, 0);
      idle(12);
      check_eq("t4_sync_payload_err", {31'd0, load_err}, {31'd0, m_err});

      // Case 5: sync byte held valid through the commit.
      for (int k = 0; k < 8; k++) p[k] = 8'($urandom_range(0, 255));
      cs = 8'd0;
      for (int k = 0; k < 8; k++) cs = cs + p[k];
      send_pkt(p, cs, 0);
      send_byte(8'hA5, 0, w);
      check_eq("t5_wait", w, 32'd8);
      check_eq("t5_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 8; k++) send_byte(p[k], 0, w);
      send_byte(cs, 0, w);
      idle(12);
      check_eq("t5_err", {31'd0, load_err}, {31'd0, m_err});

      // Case 6: reset after the third commit write.
      send_pkt(p, cs, 0);
      idle(2);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_async_wr", {20'd0, wr_a, wr_b, wr_index, wr_data}, 32'd0);
      check_eq("t6_async_busy", {31'd0, busy}, 32'd0);
      check_eq("t6_async_ready", {31'd0, s_ready}, 32'd1);
      exp_q.delete();
      done_exp--;
      m_state = 0; m_err = 1'b0; idle_run = 0;
      idle(2);
      check_eq("t6_no_done", {31'd0, load_done}, 32'd0);
      rst = 1'b0;
      idle(2);
      for (int k = 0; k < 8; k++) p[k] = 8'($urandom_range(0, 255));
      cs = 8'd0;
      for (int k = 0; k < 8; k++) cs = cs + p[k];
      send_pkt(p, cs, 2);
      idle(12);
      check_eq("t6_reload_err", {31'd0, load_err}, {31'd0, m_err});

      // Randomized stream: junk, random gaps, occasional timeouts and bad checksums.
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2), w);
         for (int k = 0; k < 8; k++)
            p[k] = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         cs = 8'd0;
         for (int k = 0; k < 8; k++) cs = cs + p[k];
         if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
         for (int k = 0; k < 10; k++) begin
            gap = ($urandom_range(0, 19) == 0) ? T : $urandom_range(0, 2);
            if (k == 0)      send_byte(8'hA5, gap, w);
            else if (k < 9)  send_byte(p[k-1], gap, w);
            else             send_byte(cs, gap, w);
         end
         idle(12);
         model_flush();
         check_eq("rnd_err", {31'd0, load_err}, {31'd0, m_err});
         check_eq("rnd_busy", {31'd0, busy}, {31'd0, (m_state != 0)});
      end

      idle(T + 5);
      model_flush();
      check_eq("end_busy", {31'd0, busy}, 32'd0);
      check_eq("end_err", {31'd0, load_err}, {31'd0, m_err});
      check_eq("end_queue", exp_q.size(), 32'd0);
      check_eq("end_done_count", done_seen, done_exp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
